// File: rtl/tdm_pkg.sv
// +--------------------------------------------------------------------------+
// | tdm_pkg : shared FSM state type and frame/counter sizing for tdm_demux2   |
// | Optional feature macro: TDM_DEMUX_PARITY_EN                               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package tdm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int PARITY_BITS = 2;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int w);
        return 2 * w + PARITY_BITS;
    endfunction

    // Counter must reach frame_len itself, which marks the "frame complete" cycle.
    function automatic int cnt_width(input int w);
        return $clog2(frame_len(w) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tdm_demux2_if.sv
// +--------------------------------------------------------------------------+
// | tdm_demux2_if : serial TDM input and deinterleaved word outputs           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface tdm_demux2_if #(
    parameter int W = 8
) ();
    logic          en_n;
    logic          sync;
    logic          din;
    logic [W-1:0]  a_data;
    logic [W-1:0]  b_data;
    logic          valid;
    logic [1:0]    par_err;

    modport master (
        output en_n, sync, din,
        input  a_data, b_data, valid, par_err
    );

    modport slave (
        input  en_n, sync, din,
        output a_data, b_data, valid, par_err
    );
endinterface

`default_nettype wire

// File: rtl/tdm_shreg.sv
// +--------------------------------------------------------------------------+
// | tdm_shreg : W-bit LSB-first shift register, enable, async active-low clr  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tdm_shreg #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         clr_n_i,
    input  wire logic         en_i,
    input  wire logic         din_i,
    output logic [W-1:0]      q_o
);

    logic [W-1:0] sr_q;

    // New bits enter at the MSB so the first bit received ends up at bit 0.
    always_ff @(posedge clk or negedge clr_n_i) begin
        if (!clr_n_i) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q <= {din_i, sr_q[W-1:1]};
        end
    end

    assign q_o = sr_q;

endmodule

`default_nettype wire

// File: rtl/tdm_demux2.sv
// +--------------------------------------------------------------------------+
// | tdm_demux2 : 2:1 TDM serial demultiplexer (A0,B0,A1,B1,... LSB first)     |
// | Optional feature macro: TDM_DEMUX_PARITY_EN (adds trailing A/B parity)    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    tdm_demux2_if.slave  bus
);

    localparam int             CW        = cnt_width(W);
    localparam logic [CW-1:0]  LAST_CNT  = CW'(frame_len(W));
    localparam logic [CW-1:0]  DATA_BITS = CW'(2 * W);

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   a_data_q;
    logic [W-1:0]   b_data_q;
    logic           valid_q;
    logic [1:0]     par_err_q;

    logic           active_d;
    logic           done_d;
    logic           capture_d;
    logic           in_data_d;
    logic [1:0]     sh_en_d;
    logic [1:0]     par_chk_d;
    logic [W-1:0]   word_d [2];

    assign active_d  = ~bus.en_n;
    // Count equal to the frame length means every bit is in and the words await loading.
    assign done_d    = active_d & (state_q == RECV) & (cnt_q == LAST_CNT);
    assign capture_d = active_d & ~bus.sync & (state_q == RECV) & (cnt_q != LAST_CNT);
    assign in_data_d = (cnt_q < DATA_BITS);

    // Even counts are A bits, odd counts B bits; a sync always lands in A as bit 0.
    assign sh_en_d[0] = (active_d & bus.sync) | (capture_d & in_data_d & ~cnt_q[0]);
    assign sh_en_d[1] = capture_d & in_data_d & cnt_q[0];

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        tdm_shreg #(.W(W)) u_shreg (
            .clk     (clk),
            .clr_n_i (rst_n),
            .en_i    (sh_en_d[ch]),
            .din_i   (bus.din),
            .q_o     (word_d[ch])
        );
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic par_a_q;
    logic par_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_a_q <= 1'b0;
            par_b_q <= 1'b0;
        end else if (capture_d && !in_data_d) begin
            if (cnt_q[0]) begin
                par_b_q <= bus.din;
            end else begin
                par_a_q <= bus.din;
            end
        end
    end

    assign par_chk_d = {par_b_q ^ (^word_d[1]), par_a_q ^ (^word_d[0])};
`else
    assign par_chk_d = 2'b00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 2'b00;
        end else begin
            valid_q <= 1'b0;
            if (active_d) begin
                if (done_d) begin
                    a_data_q  <= word_d[0];
                    b_data_q  <= word_d[1];
                    par_err_q <= par_chk_d;
                    valid_q   <= 1'b1;
                end
                // Sync wins in every state, so a frame can start on the load cycle.
                if (bus.sync) begin
                    state_q <= RECV;
                    cnt_q   <= CW'(1);
                end else if (done_d) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else if (state_q == RECV) begin
                    cnt_q   <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign bus.a_data  = a_data_q;
    assign bus.b_data  = b_data_q;
    assign bus.valid   = valid_q;
    assign bus.par_err = par_err_q;

endmodule

`default_nettype wire
